// File: rtl/gauss_frame_sequencer.sv
// gauss_frame_sequencer
// Frame-level controller for the 3-row Gaussian blur datapath. For every
// centre row it streams one column per cycle of row-aligned read addresses
// (top/mid/bottom) into the frame memory, pulses the filter enable at the
// start of each row, and uses a valid shift register matched to the
// memory+filter latency to write each filtered pixel to the output memory.
//
// Optional feature macro: BORDER_REPLICATE_EN
//   undefined : interior-only output, (IMG_W-2) x (IMG_H-2) pixels
//   defined   : full-size output, edge rows/columns replicated, IMG_W x IMG_H

module gauss_frame_sequencer #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int ADDR_W  = 19,
  parameter int FLT_LAT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_top,
  output logic [ADDR_W-1:0] rd_addr_mid,
  output logic [ADDR_W-1:0] rd_addr_bot,
  output logic              flt_enable,
  input  logic [7:0]        flt_pixel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

`ifdef BORDER_REPLICATE_EN
  // Two extra feed cycles replicate the first and last columns.
  localparam int FEED_LEN  = IMG_W + 2;
  localparam int FIRST_ROW = 0;
  localparam int LAST_ROW  = IMG_H - 1;
`else
  localparam int FEED_LEN  = IMG_W;
  localparam int FIRST_ROW = 1;
  localparam int LAST_ROW  = IMG_H - 2;
`endif

  localparam int FEED_W  = $clog2(FEED_LEN + 1);
  localparam int DRAIN_W = $clog2(FLT_LAT + 1);
  localparam int ROW_W   = $clog2(IMG_H + 1);

  localparam logic [FEED_W-1:0]  FEED_LAST   = FEED_W'(FEED_LEN - 1);
  localparam logic [FEED_W-1:0]  FEED_INJECT = FEED_W'(2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(FLT_LAT - 1);
  localparam logic [ROW_W-1:0]   ROW_FIRST   = ROW_W'(FIRST_ROW);
  localparam logic [ROW_W-1:0]   ROW_LAST    = ROW_W'(LAST_ROW);
  localparam logic [ADDR_W-1:0]  ROW_STRIDE  = ADDR_W'(IMG_W);

`ifdef BORDER_REPLICATE_EN
  // Row 0: top row is clamped onto row 0, bottom row is row 1.
  localparam logic [ADDR_W-1:0] TOP_BASE0 = '0;
  localparam logic [ADDR_W-1:0] MID_BASE0 = '0;
  localparam logic [ADDR_W-1:0] BOT_BASE0 = ADDR_W'(IMG_W);
  // From this centre row on, the next row's bottom neighbour stays on IMG_H-1.
  localparam logic [ROW_W-1:0]  ROW_BOT_CLAMP = ROW_W'(IMG_H - 2);
  // Last feed index at which the column still advances (column = index-1 clamped).
  localparam logic [FEED_W-1:0] COL_STEP_LAST = FEED_W'(IMG_W - 1);
`else
  // Row 1: neighbours are rows 0 and 2.
  localparam logic [ADDR_W-1:0] TOP_BASE0 = '0;
  localparam logic [ADDR_W-1:0] MID_BASE0 = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BOT_BASE0 = ADDR_W'(2 * IMG_W);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [FEED_W-1:0]   feedIdx_q;
  logic [DRAIN_W-1:0]  drainCnt_q;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   topBase_q;
  logic [ADDR_W-1:0]   midBase_q;
  logic [ADDR_W-1:0]   botBase_q;
  logic [ADDR_W-1:0]   rdAddrTop_q;
  logic [ADDR_W-1:0]   rdAddrMid_q;
  logic [ADDR_W-1:0]   rdAddrBot_q;
  logic                busy_q;
  logic                frameDone_q;
  logic                rdEn_q;
  logic                fltEnable_q;
  logic [FLT_LAT-1:0]  vld_q;
  logic [ADDR_W-1:0]   wrAddr_q;

  logic [ADDR_W-1:0]   topBase_d;
  logic [ADDR_W-1:0]   midBase_d;
  logic [ADDR_W-1:0]   botBase_d;
  logic                colStep_d;
  logic                inject_d;

  // Row base addresses for the next centre row, derived from the current ones.
  always_comb begin
    topBase_d = midBase_q;
    midBase_d = midBase_q + ROW_STRIDE;
    botBase_d = botBase_q + ROW_STRIDE;
`ifdef BORDER_REPLICATE_EN
    if (row_q >= ROW_BOT_CLAMP) begin
      botBase_d = botBase_q;
    end
`endif
  end

  // Whether the read column moves on after the current feed cycle, and whether
  // the current read produces a complete filter window.
  always_comb begin
`ifdef BORDER_REPLICATE_EN
    colStep_d = (feedIdx_q != '0) && (feedIdx_q <= COL_STEP_LAST);
`else
    colStep_d = 1'b1;
`endif
    inject_d = rdEn_q && (feedIdx_q >= FEED_INJECT);
  end

  // Frame sequencing FSM with registered read-side outputs and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      feedIdx_q   <= '0;
      drainCnt_q  <= '0;
      row_q       <= '0;
      topBase_q   <= '0;
      midBase_q   <= '0;
      botBase_q   <= '0;
      rdAddrTop_q <= '0;
      rdAddrMid_q <= '0;
      rdAddrBot_q <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      rdEn_q      <= 1'b0;
      fltEnable_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      fltEnable_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FEED;
            busy_q      <= 1'b1;
            rdEn_q      <= 1'b1;
            fltEnable_q <= 1'b1;
            feedIdx_q   <= '0;
            row_q       <= ROW_FIRST;
            topBase_q   <= TOP_BASE0;
            midBase_q   <= MID_BASE0;
            botBase_q   <= BOT_BASE0;
            rdAddrTop_q <= TOP_BASE0;
            rdAddrMid_q <= MID_BASE0;
            rdAddrBot_q <= BOT_BASE0;
          end
        end
        S_FEED: begin
          if (feedIdx_q == FEED_LAST) begin
            state_q    <= S_DRAIN;
            rdEn_q     <= 1'b0;
            drainCnt_q <= '0;
          end else begin
            feedIdx_q <= feedIdx_q + 1'b1;
            if (colStep_d) begin
              rdAddrTop_q <= rdAddrTop_q + 1'b1;
              rdAddrMid_q <= rdAddrMid_q + 1'b1;
              rdAddrBot_q <= rdAddrBot_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drainCnt_q == DRAIN_LAST) begin
            if (row_q == ROW_LAST) begin
              state_q     <= S_DONE;
              busy_q      <= 1'b0;
              frameDone_q <= 1'b1;
            end else begin
              state_q     <= S_FEED;
              rdEn_q      <= 1'b1;
              fltEnable_q <= 1'b1;
              feedIdx_q   <= '0;
              row_q       <= row_q + 1'b1;
              topBase_q   <= topBase_d;
              midBase_q   <= midBase_d;
              botBase_q   <= botBase_d;
              rdAddrTop_q <= topBase_d;
              rdAddrMid_q <= midBase_d;
              rdAddrBot_q <= botBase_d;
            end
          end else begin
            drainCnt_q <= drainCnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Valid pipeline tracking which reads emerge from the filter as output pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= inject_d;
      for (int i = 1; i < FLT_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Output write address: restarts for each accepted frame, steps after each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrAddr_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      wrAddr_q <= '0;
    end else if (vld_q[FLT_LAT-1]) begin
      wrAddr_q <= wrAddr_q + 1'b1;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frameDone_q;
  assign rd_en       = rdEn_q;
  assign rd_addr_top = rdAddrTop_q;
  assign rd_addr_mid = rdAddrMid_q;
  assign rd_addr_bot = rdAddrBot_q;
  assign flt_enable  = fltEnable_q;
  assign wr_en       = vld_q[FLT_LAT-1];
  assign wr_addr     = wrAddr_q;
  assign wr_data     = flt_pixel;

endmodule

// File: tb/tb_gauss_frame_sequencer.sv
// tb_gauss_frame_sequencer
// Drives gauss_frame_sequencer with randomized start/reset timing and random
// filter pixels. A frame-level reference model queues every expected read,
// filter enable, write and frame_done with its cycle; a monitor pops and
// compares whenever the DUT presents one of those events.

module tb_gauss_frame_sequencer;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int AW     = 8;
  localparam int LAT    = 5;

`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam int FEED_LEN  = BORDER ? W + 2 : W;
  localparam int FIRST_ROW = BORDER ? 0 : 1;
  localparam int ROWS      = BORDER ? H : H - 2;

  typedef struct {
    int cyc;
    int top;
    int mid;
    int bot;
  } rdExp_t;

  typedef struct {
    int cyc;
    int addr;
  } wrExp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr_top;
  logic [AW-1:0] rd_addr_mid;
  logic [AW-1:0] rd_addr_bot;
  logic          flt_enable;
  logic [7:0]    flt_pixel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monitorOn = 1'b0;
  int zeroCheckCycle = -1;
  int idleFrom = 0;
  int busyFrom = 0;
  int busyTo = 0;
  int lastAccept = 0;
  int lastDoneCycle = 0;

  rdExp_t rdQ[$];
  wrExp_t wrQ[$];
  int     enQ[$];
  int     doneQ[$];

  rdExp_t rdE;
  wrExp_t wrE;
  int     expCyc;

  gauss_frame_sequencer #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW),
    .FLT_LAT(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr_top(rd_addr_top),
    .rd_addr_mid(rd_addr_mid),
    .rd_addr_bot(rd_addr_bot),
    .flt_enable (flt_enable),
    .flt_pixel  (flt_pixel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter; cycle N is the interval following the N-th rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model: a frame accepted in cycle t produces, row by row, one read
  // per feed cycle, one enable per row, one write per complete 3x3 window
  // LAT cycles after the read that completes it, and frame_done at the end.
  task automatic pushFrame(input int t);
    int waddr;
    int rowStart;
    int r;
    int c;
    int topRow;
    int botRow;
    rdExp_t re;
    wrExp_t we;
    waddr = 0;
    for (int ri = 0; ri < ROWS; ri++) begin
      r        = FIRST_ROW + ri;
      rowStart = t + 1 + ri * (FEED_LEN + LAT);
      topRow   = BORDER ? clampi(r - 1, 0, H - 1) : r - 1;
      botRow   = BORDER ? clampi(r + 1, 0, H - 1) : r + 1;
      enQ.push_back(rowStart);
      for (int k = 0; k < FEED_LEN; k++) begin
        c      = BORDER ? clampi(k - 1, 0, W - 1) : k;
        re.cyc = rowStart + k;
        re.top = topRow * W + c;
        re.mid = r * W + c;
        re.bot = botRow * W + c;
        rdQ.push_back(re);
        if (k >= 2) begin
          we.cyc  = rowStart + k + LAT;
          we.addr = waddr;
          wrQ.push_back(we);
          waddr++;
        end
      end
    end
    lastDoneCycle = t + 1 + ROWS * (FEED_LEN + LAT);
    doneQ.push_back(lastDoneCycle);
    busyFrom = t + 1;
    busyTo   = lastDoneCycle;
    idleFrom = lastDoneCycle + 1;
    lastAccept = t;
  endtask

  // Drives one cycle of inputs, updates the model, and advances to the next cycle.
  task automatic applyStimulus(input bit doStart, input bit doReset);
    start     = doStart;
    reset     = doReset;
    flt_pixel = 8'($urandom);
    if (!doReset && doStart && (cyc >= idleFrom)) begin
      pushFrame(cyc);
    end
    @(posedge clk);
    #1;
    if (doReset) begin
      rdQ.delete();
      wrQ.delete();
      enQ.delete();
      doneQ.delete();
      idleFrom       = cyc;
      busyFrom       = 0;
      busyTo         = 0;
      zeroCheckCycle = cyc;
      monitorOn      = 1'b1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  // Starts a frame and runs it through its frame_done cycle, optionally
  // sprinkling extra start pulses (always including the frame_done cycle).
  task automatic runFrame(input bit spurious);
    int doneAt;
    applyStimulus(1'b1, 1'b0);
    doneAt = lastDoneCycle;
    for (int n = 0; n < 200 && cyc <= doneAt; n++) begin
      applyStimulus(spurious && ((cyc == doneAt) || ($urandom_range(0, 3) == 0)), 1'b0);
    end
  endtask

  // Monitor: on the falling edge, compare whatever the DUT presents with the
  // head of the matching expectation queue, plus busy and post-reset state.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (cyc == zeroCheckCycle) begin
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_rd_en", int'(rd_en), 0);
        checkOutput("rst_flt_enable", int'(flt_enable), 0);
        checkOutput("rst_wr_en", int'(wr_en), 0);
        checkOutput("rst_wr_addr", int'(wr_addr), 0);
        checkOutput("rst_rd_addr_top", int'(rd_addr_top), 0);
        checkOutput("rst_rd_addr_mid", int'(rd_addr_mid), 0);
        checkOutput("rst_rd_addr_bot", int'(rd_addr_bot), 0);
      end
      checkOutput("busy", int'(busy), int'((cyc >= busyFrom) && (cyc < busyTo)));
      if (flt_enable) begin
        if (enQ.size() == 0) begin
          checkOutput("flt_enable_unexpected", 1, 0);
        end else begin
          expCyc = enQ.pop_front();
          checkOutput("flt_enable_cycle", cyc, expCyc);
        end
      end
      if (rd_en) begin
        if (rdQ.size() == 0) begin
          checkOutput("rd_unexpected", 1, 0);
        end else begin
          rdE = rdQ.pop_front();
          checkOutput("rd_cycle", cyc, rdE.cyc);
          checkOutput("rd_addr_top", int'(rd_addr_top), rdE.top);
          checkOutput("rd_addr_mid", int'(rd_addr_mid), rdE.mid);
          checkOutput("rd_addr_bot", int'(rd_addr_bot), rdE.bot);
        end
      end
      if (wr_en) begin
        if (wrQ.size() == 0) begin
          checkOutput("wr_unexpected", 1, 0);
        end else begin
          wrE = wrQ.pop_front();
          checkOutput("wr_cycle", cyc, wrE.cyc);
          checkOutput("wr_addr", int'(wr_addr), wrE.addr);
          checkOutput("wr_data", int'(wr_data), int'(flt_pixel));
        end
      end
      if (frame_done) begin
        if (doneQ.size() == 0) begin
          checkOutput("frame_done_unexpected", 1, 0);
        end else begin
          expCyc = doneQ.pop_front();
          checkOutput("frame_done_cycle", cyc, expCyc);
        end
      end
    end
  end

  // Test sequence: reset, plain frame, frames with ignored starts and a
  // back-to-back restart, reset racing start, mid-frame abort, clean frame.
  initial begin
    int target;
    reset     = 1'b1;
    start     = 1'b0;
    flt_pixel = 8'h00;
    $display("[TB] gauss_frame_sequencer bench, IMG_W=%0d IMG_H=%0d border=%0d", W, H, BORDER);

    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 1'b0);

    runFrame(1'b0);
    repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0);

    runFrame(1'b1);
    runFrame(1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0);
    target = lastAccept + 1 + (FEED_LEN + LAT) + FEED_LEN + int'($urandom_range(0, LAT - 1));
    for (int n = 0; n < 200 && cyc < target; n++) begin
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);

    runFrame(1'b0);
    repeat (LAT + 3) applyStimulus(1'b0, 1'b0);

    checkOutput("rd_pending", rdQ.size(), 0);
    checkOutput("wr_pending", wrQ.size(), 0);
    checkOutput("enable_pending", enQ.size(), 0);
    checkOutput("done_pending", doneQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_frame_sequencer.md
Name: gauss_frame_sequencer

Overview:
Frame-level controller that sequences the 3-row Gaussian blur datapath over a stored image. It generates three row-aligned read addresses per column for the frame memory, whose 1-cycle read data drives the filter's In1/In2/In3 directly. It pulses the filter enable at each row start, tracks pipeline latency and writes each filtered pixel to the output memory at the correct address. It sits between the frame buffer, the filter and the output buffer; a host starts it and waits for frame_done.

Parameters:
IMG_W, 640, image width in pixels (>=3)
IMG_H, 480, image height in pixels (>=3)
ADDR_W, 19, address width for frame and output memories (>= clog2(IMG_W*IMG_H))
FLT_LAT, 5, cycles from rd_en issue to valid flt_pixel (1 memory + 4 filter stages)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from the cycle after accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last write of the frame
rd_en  out  1  frame-memory read strobe
rd_addr_top  out  ADDR_W  address of pixel (row r-1, col c); feeds In1
rd_addr_mid  out  ADDR_W  address of pixel (row r, col c); feeds In2
rd_addr_bot  out  ADDR_W  address of pixel (row r+1, col c); feeds In3
flt_enable  out  1  one-cycle pulse to filter enable at first feed cycle of each row
flt_pixel  in  8  filter gaussian output
wr_en  out  1  output-memory write strobe
wr_addr  out  ADDR_W  output pixel address
wr_data  out  8  equals flt_pixel (combinational passthrough)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset: state IDLE; busy, frame_done, rd_en, flt_enable, wr_en = 0; all addresses and counters = 0; valid shift register cleared. Reset mid-frame aborts the frame; pending writes are discarded, no frame_done.
- States: IDLE -> FEED on start. FEED: IMG_W cycles, col c = 0..IMG_W-1, rd_en=1, row addresses = (r-1)*IMG_W+c, r*IMG_W+c, (r+1)*IMG_W+c. Centre row r runs 1..IMG_H-2. FEED -> DRAIN after c=IMG_W-1. DRAIN: FLT_LAT cycles, rd_en=0. DRAIN -> FEED with r+1 if r<IMG_H-2, else -> DONE. DONE: frame_done=1 for one cycle -> IDLE.
- flt_enable=1 only in cycle c=0 of each FEED.
- Write scheduling: FLT_LAT-deep valid shift register; bit injected = rd_en && c>=2. wr_en = shift output. wr_addr starts at 0 per frame and increments after each write. Writes per row = IMG_W-2. Writes per frame = (IMG_W-2)*(IMG_H-2). Output image is row-major, (IMG_W-2) wide.
- Cycles per row = IMG_W+FLT_LAT; last write lands in final DRAIN cycle; frame_done asserts the following cycle.
- start while busy or in DONE: ignored. start in same cycle as reset: reset wins.
- Address arithmetic unsigned, ADDR_W bits; no wrap for legal parameters.

Optional Feature:
BORDER_REPLICATE_EN. Defined: full-size output IMG_W x IMG_H. r runs 0..IMG_H-1, top row = max(r-1,0), bottom row = min(r+1,IMG_H-1). FEED lasts IMG_W+2 cycles with column index clamped to [0,IMG_W-1] (sequence 0,0,1,..,W-1,W-1). Valid bit injected from the 3rd feed cycle on. IMG_W writes per row, IMG_W*IMG_H per frame. Undefined: interior-only behaviour above.

Test Plan:
- IMG_W=8, IMG_H=4, single start -> exactly 12 wr_en pulses, wr_addr 0..11 in order, frame_done once, 2*(8+5)+1 cycles after start accept.
- Row 1 feed, c=3 -> rd_addr_top=3, rd_addr_mid=11, rd_addr_bot=19; first wr_en appears 5 cycles after the c=2 read.
- flt_pixel driven with a cycle counter -> each wr_data equals flt_pixel in the wr_en cycle; flt_enable pulses exactly once per row (2 pulses).
- start re-pulsed mid-frame -> ignored, write count still 12; reset asserted during row 2 DRAIN -> all outputs 0 next cycle, no frame_done, next start produces a clean full frame.
- Back-to-back: start in cycle after frame_done -> second frame identical in timing and addresses.
- BORDER_REPLICATE_EN defined, IMG_W=8, IMG_H=4 -> 32 writes; row 0 top address equals mid address; first column read twice, last column read twice.
